imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, instruction-memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter AW, default 10, memory word-index width, equal to log2(DEPTH).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 f_req_valid / f_req_ready  in/out  1/1  fetch request handshake.
REQ-006 f_addr  in  32  fetch byte address.
REQ-007 f_rsp_valid / f_rsp_ready  out/in  1/1  fetch response handshake.
REQ-008 f_rsp_data / f_rsp_err  out  32/1  fetched instruction; address error flag.
REQ-009 l_req_valid / l_req_ready  in/out  1/1  loader write request handshake.
REQ-010 l_addr / l_wdata  in  32/32  loader byte address and write word.
REQ-011 l_ack / l_err  out  1/1  one-cycle write-completion pulse; write-dropped flag, valid with l_ack.
REQ-012 m_en / m_we  out  1/1  memory access strobe; write enable.
REQ-013 m_addr / m_wdata / m_rdata  out/out/in  AW/32/32  word index, write data, read data (synchronous, 1-cycle read latency).

Function
REQ-014 Transfers occur only when valid and ready are both high at a rising edge; at most one memory access per cycle.
REQ-015 A fetch request is legal iff f_addr[1:0]==0 and f_addr[31:2] < DEPTH; a loader request uses the same legality rule on l_addr.
REQ-016 Legal accepted request in cycle N drives m_en=1 combinationally in cycle N, m_addr=addr[AW+1:2], m_we=1 for loader, 0 for fetch.
REQ-017 Illegal request is accepted but drives m_en=0; fetch returns f_rsp_err=1 and f_rsp_data=0; loader returns l_err=1.
REQ-018 Accepted fetch in cycle N: f_rsp_valid=1 in cycle N+1 with f_rsp_data=m_rdata; f_rsp_err=0 for legal requests.
REQ-019 Accepted loader write in cycle N: l_ack=1 for exactly cycle N+1; l_err valid in that cycle.
REQ-020 Response FSM states: IDLE (no response outstanding), RSP (response presented directly from memory), HOLD (response stalled, data in skid register).
REQ-021 IDLE->RSP on fetch acceptance; RSP->RSP on response consumed with new fetch accepted; RSP->IDLE on consumed with no new fetch; RSP->HOLD when f_rsp_ready=0, capturing m_rdata/err into skid register; HOLD->IDLE when f_rsp_ready=1.
REQ-022 f_req_ready=1 only when fetch holds the grant and (state==IDLE or (state==RSP and f_rsp_ready==1)); no fetch accepted in HOLD.
REQ-023 Back-to-back fetches with f_rsp_ready held high SHALL sustain one response per cycle.
REQ-024 l_req_ready=1 only when loader holds the grant; loader writes proceed in any response state, including HOLD.
REQ-025 Loader write to word W accepted in cycle N; fetch of W accepted in cycle N+1 or later SHALL return the new data.
REQ-026 A response held in HOLD SHALL NOT change when a loader write to the same word occurs.
REQ-027 When only one requester is valid, it holds the grant.

Reset
REQ-028 On rst_n low, immediately: state=IDLE, f_rsp_valid=0, f_rsp_err=0, f_rsp_data=0, l_ack=0, l_err=0, m_en=0, m_we=0, skid register cleared, arbitration pointer set to favour loader.
REQ-029 An outstanding response or write acknowledgement in flight at reset SHALL be discarded, not presented after release.

Configuration
REQ-030 With IMEM_ARB_RR_EN defined: when both request, grant round-robin; the pointer toggles after every granted transfer and favours the requester not last served.
REQ-031 With IMEM_ARB_RR_EN undefined: the loader always wins simultaneous requests; the arbitration pointer is absent.

Verification
REQ-032 Reset, load words 0x00000013 at 0x0 and 0x00500093 at 0x4, fetch 0x4 -> f_rsp_valid one cycle after accept, data 0x00500093, err 0.
REQ-033 Fetch 0x0,0x4,0x8 on consecutive cycles with f_rsp_ready=1 -> three responses on three consecutive cycles, in order.
REQ-034 Fetch 0x0, hold f_rsp_ready=0 for 3 cycles -> HOLD entered, data stable, f_req_ready=0; loader write to 0x0 in HOLD does not alter held data.
REQ-035 Fetch 0x2 and fetch 0x1000 with DEPTH=1024 -> f_rsp_err=1, data 0, m_en never asserted; loader write to 0x1000 -> l_ack with l_err=1.
REQ-036 Both requesters valid 4 cycles -> with IMEM_ARB_RR_EN grants L,F,L,F; without it grants L,L,L,L.
REQ-037 Assert rst_n low during RSP -> f_rsp_valid low immediately, no response after release.

Source files
------------

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Arbitrates a fetch port and a loader write port onto one
//               synchronous instruction memory. The fetch response path has a
//               skid register so stalls do not lose read data.
//               Optional round-robin arbitration is enabled by IMEM_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          f_req_valid_i,
   output logic          f_req_ready_o,
   input  logic [31:0]   f_addr_i,
   output logic          f_rsp_valid_o,
   input  logic          f_rsp_ready_i,
   output logic [31:0]   f_rsp_data_o,
   output logic          f_rsp_err_o,
   input  logic          l_req_valid_i,
   output logic          l_req_ready_o,
   input  logic [31:0]   l_addr_i,
   input  logic [31:0]   l_wdata_i,
   output logic          l_ack_o,
   output logic          l_err_o,
   output logic          m_en_o,
   output logic          m_we_o,
   output logic [AW-1:0] m_addr_o,
   output logic [31:0]   m_wdata_o,
   input  logic [31:0]   m_rdata_i
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RSP  = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   function automatic logic addr_legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < DEPTH_W);
   endfunction

   state_e      state_q, state_d;
   logic        err_q, err_d;
   logic [31:0] skid_data_q, skid_data_d;
   logic        skid_err_q, skid_err_d;
   logic        l_ack_q, l_ack_d;
   logic        l_err_q, l_err_d;

   logic        f_legal, l_legal;
   logic        f_room, f_cand;
   logic        f_gnt, l_gnt;
   logic        f_fire, l_fire;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_data;

   assign f_legal = addr_legal(f_addr_i);
   assign l_legal = addr_legal(l_addr_i);

   // A fetch only competes when the response path can take another beat, so a
   // stalled response never blocks the loader.
   assign f_room = (state_q == S_IDLE) || ((state_q == S_RSP) && f_rsp_ready_i);
   assign f_cand = f_req_valid_i && f_room;

`ifdef IMEM_ARB_RR_EN
   logic prio_l_q, prio_l_d;

   assign l_gnt = l_req_valid_i && (!f_cand || prio_l_q);

   always_comb begin
      prio_l_d = prio_l_q;
      if (l_fire) begin
         prio_l_d = 1'b0;
      end else if (f_fire) begin
         prio_l_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_l_q <= 1'b1;
      end else begin
         prio_l_q <= prio_l_d;
      end
   end
`else
   assign l_gnt = l_req_valid_i;
`endif

   assign f_gnt = f_cand && !l_gnt;

   assign l_req_ready_o = rst_ni && l_gnt;
   assign f_req_ready_o = rst_ni && f_gnt;

   assign l_fire = l_req_valid_i && l_req_ready_o;
   assign f_fire = f_req_valid_i && f_req_ready_o;

   assign m_en_o    = (l_fire && l_legal) || (f_fire && f_legal);
   assign m_we_o    = l_fire && l_legal;
   assign m_addr_o  = l_gnt ? l_addr_i[AW+1:2] : f_addr_i[AW+1:2];
   assign m_wdata_o = l_wdata_i;

   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;
      rsp_valid   = 1'b0;
      rsp_err     = 1'b0;
      rsp_data    = '0;
      case (state_q)
         S_IDLE: begin
            if (f_fire) begin
               state_d = S_RSP;
               err_d   = !f_legal;
            end
         end
         S_RSP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_data  = err_q ? 32'h0 : m_rdata_i;
            if (f_rsp_ready_i) begin
               if (f_fire) begin
                  state_d = S_RSP;
                  err_d   = !f_legal;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               // Memory output is only valid this cycle; park it.
               state_d     = S_HOLD;
               skid_data_d = rsp_data;
               skid_err_d  = err_q;
            end
         end
         S_HOLD: begin
            rsp_valid = 1'b1;
            rsp_err   = skid_err_q;
            rsp_data  = skid_data_q;
            if (f_rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign l_ack_d = l_fire;
   assign l_err_d = l_fire && !l_legal;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         err_q       <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
         l_ack_q     <= 1'b0;
         l_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         skid_data_q <= skid_data_d;
         skid_err_q  <= skid_err_d;
         l_ack_q     <= l_ack_d;
         l_err_q     <= l_err_d;
      end
   end

   assign f_rsp_valid_o = rsp_valid;
   assign f_rsp_data_o  = rsp_data;
   assign f_rsp_err_o   = rsp_err;
   assign l_ack_o       = l_ack_q;
   assign l_err_o       = l_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// Testbench for imem_arbiter: scoreboard of expected fetch responses and
// loader acknowledgements against a behavioural synchronous memory.
module tb_imem_arbiter;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } frsp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          f_req_valid, f_req_ready;
   logic [31:0]   f_addr;
   logic          f_rsp_valid, f_rsp_ready;
   logic [31:0]   f_rsp_data;
   logic          f_rsp_err;
   logic          l_req_valid, l_req_ready;
   logic [31:0]   l_addr, l_wdata;
   logic          l_ack, l_err;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [31:0]   m_rdata;

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   frsp_t       fq[$];
   logic        lq[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          men_count = 0;

   always #5 clk = ~clk;

   imem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .f_req_valid_i(f_req_valid), .f_req_ready_o(f_req_ready), .f_addr_i(f_addr),
      .f_rsp_valid_o(f_rsp_valid), .f_rsp_ready_i(f_rsp_ready),
      .f_rsp_data_o(f_rsp_data), .f_rsp_err_o(f_rsp_err),
      .l_req_valid_i(l_req_valid), .l_req_ready_o(l_req_ready),
      .l_addr_i(l_addr), .l_wdata_i(l_wdata), .l_ack_o(l_ack), .l_err_o(l_err),
      .m_en_o(m_en), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
      .m_rdata_i(m_rdata)
   );

   // Write-through synchronous RAM: a write also updates the read port.
   always @(posedge clk) begin
      if (m_en) begin
         men_count <= men_count + 1;
         if (m_we) begin
            mem[m_addr] <= m_wdata;
            m_rdata     <= m_wdata;
         end else begin
            m_rdata <= mem[m_addr];
         end
      end
   end

   function automatic logic tb_legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a < 32'h0000_1000);
   endfunction

   function automatic frsp_t exp_fetch(input logic [31:0] a);
      frsp_t r;
      r.err  = !tb_legal(a);
      r.data = r.err ? 32'h0 : ref_mem[a[11:2]];
      return r;
   endfunction

   task automatic load_word(input logic [31:0] a, input logic [31:0] d);
      int w;
      w = 0;
      @(posedge clk); #1;
      l_req_valid = 1'b1; l_addr = a; l_wdata = d;
      @(negedge clk);
      while (!l_req_ready && w < 20) begin w++; @(negedge clk); end
      n_checks++;
      if (l_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL load_accept: l_req_ready=%b required 1 addr=%h", l_req_ready, a);
      end else begin
         lq.push_back(!tb_legal(a));
         if (tb_legal(a)) ref_mem[a[11:2]] = d;
      end
      @(posedge clk); #1;
      l_req_valid = 1'b0;
   endtask

   task automatic issue_fetch(input logic [31:0] a);
      int w;
      w = 0;
      @(posedge clk); #1;
      f_req_valid = 1'b1; f_addr = a;
      @(negedge clk);
      while (!f_req_ready && w < 20) begin w++; @(negedge clk); end
      n_checks++;
      if (f_req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fetch_accept: f_req_ready=%b required 1 addr=%h", f_req_ready, a);
      end else begin
         fq.push_back(exp_fetch(a));
      end
      @(posedge clk); #1;
      f_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      f_req_valid = 1'b1; f_addr = 32'h0; f_rsp_ready = 1'b1;
      l_req_valid = 1'b1; l_addr = 32'h0; l_wdata = 32'h1;
      @(negedge clk);
      n_checks++;
      if (m_en !== 1'b0 || m_we !== 1'b0) begin
         n_fail++; $display("FAIL reset_mem: m_en=%b m_we=%b required 0 0", m_en, m_we);
      end
      n_checks++;
      if (f_rsp_valid !== 1'b0 || f_rsp_err !== 1'b0 || f_rsp_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rsp: valid=%b err=%b data=%h required 0 0 0", f_rsp_valid, f_rsp_err, f_rsp_data);
      end
      n_checks++;
      if (l_ack !== 1'b0 || l_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_ack: l_ack=%b l_err=%b required 0 0", l_ack, l_err);
      end
      f_req_valid = 1'b0; l_req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_load_fetch();
      frsp_t e;
      logic  le;
      load_word(32'h0, 32'h0000_0013);
      @(negedge clk);
      n_checks++;
      if (l_ack !== 1'b1 || lq.size() == 0) begin
         n_fail++; $display("FAIL lf_ack0: l_ack=%b required 1", l_ack);
      end else begin
         le = lq.pop_front(); n_checks++;
         if (l_err !== le) begin n_fail++; $display("FAIL lf_err0: l_err=%b required %b", l_err, le); end
      end
      @(negedge clk);
      n_checks++;
      if (l_ack !== 1'b0) begin n_fail++; $display("FAIL lf_ack_pulse: l_ack=%b required 0", l_ack); end
      load_word(32'h4, 32'h0050_0093);
      @(negedge clk);
      n_checks++;
      if (l_ack !== 1'b1 || lq.size() == 0) begin
         n_fail++; $display("FAIL lf_ack1: l_ack=%b required 1", l_ack);
      end else void'(lq.pop_front());
      issue_fetch(32'h4);
      @(negedge clk);
      n_checks++;
      if (f_rsp_valid !== 1'b1 || fq.size() == 0) begin
         n_fail++; $display("FAIL lf_rsp_valid: f_rsp_valid=%b required 1", f_rsp_valid);
      end else begin
         e = fq.pop_front(); n_checks++;
         if (f_rsp_data !== e.data || f_rsp_err !== e.err || e.data !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL lf_rsp: data=%h err=%b required data=%h err=%b", f_rsp_data, f_rsp_err, 32'h0050_0093, 1'b0);
         end
      end
   endtask

   task automatic test_back_to_back();
      frsp_t e;
      load_word(32'h8, 32'h00A0_0113);
      @(negedge clk);
      if (lq.size() != 0) void'(lq.pop_front());
      @(posedge clk); #1;
      f_req_valid = 1'b1; f_addr = 32'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if (f_rsp_valid !== 1'b1 || fq.size() == 0) begin
               n_fail++; $display("FAIL b2b_valid%0d: f_rsp_valid=%b required 1", i, f_rsp_valid);
            end else begin
               e = fq.pop_front(); n_checks++;
               if (f_rsp_data !== e.data || f_rsp_err !== e.err) begin
                  n_fail++;
                  $display("FAIL b2b_data%0d: data=%h err=%b required data=%h err=%b", i, f_rsp_data, f_rsp_err, e.data, e.err);
               end
            end
         end
         if (i < 3) begin
            n_checks++;
            if (f_req_ready !== 1'b1) begin
               n_fail++; $display("FAIL b2b_ready%0d: f_req_ready=%b required 1", i, f_req_ready);
            end else fq.push_back(exp_fetch(f_addr));
         end
         @(posedge clk); #1;
         if (i < 2) f_addr = f_addr + 32'h4;
         else f_req_valid = 1'b0;
      end
   endtask

   task automatic test_hold();
      frsp_t e;
      logic  le;
      f_rsp_ready = 1'b0;
      issue_fetch(32'h0);
      f_req_valid = 1'b1; f_addr = 32'h4;
      for (int h = 0; h < 4; h++) begin
         @(negedge clk);
         n_checks++;
         if (f_rsp_valid !== 1'b1 || fq.size() == 0 || f_rsp_data !== fq[0].data) begin
            n_fail++;
            $display("FAIL hold_data%0d: valid=%b data=%h required valid=1 data=%h", h, f_rsp_valid, f_rsp_data, 32'h0000_0013);
         end
         n_checks++;
         if (f_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL hold_fready%0d: f_req_ready=%b required 0", h, f_req_ready);
         end
         if (h == 1) begin
            n_checks++;
            if (l_req_ready !== 1'b1) begin
               n_fail++; $display("FAIL hold_lready: l_req_ready=%b required 1", l_req_ready);
            end else begin
               lq.push_back(1'b0);
               ref_mem[0] = l_wdata;
            end
         end
         if (h == 2) begin
            n_checks++;
            if (l_ack !== 1'b1 || lq.size() == 0) begin
               n_fail++; $display("FAIL hold_ack: l_ack=%b required 1", l_ack);
            end else begin
               le = lq.pop_front(); n_checks++;
               if (l_err !== le) begin n_fail++; $display("FAIL hold_lerr: l_err=%b required %b", l_err, le); end
            end
         end
         @(posedge clk); #1;
         if (h == 0) begin l_req_valid = 1'b1; l_addr = 32'h0; l_wdata = 32'hDEAD_BEEF; end
         if (h == 1) l_req_valid = 1'b0;
      end
      f_req_valid = 1'b0;
      f_rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (f_rsp_valid !== 1'b1 || fq.size() == 0) begin
         n_fail++; $display("FAIL hold_release: f_rsp_valid=%b required 1", f_rsp_valid);
      end else begin
         e = fq.pop_front(); n_checks++;
         if (f_rsp_data !== e.data || f_rsp_err !== e.err) begin
            n_fail++; $display("FAIL hold_final: data=%h required %h", f_rsp_data, e.data);
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (f_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_idle: f_rsp_valid=%b required 0", f_rsp_valid); end
      issue_fetch(32'h0);
      @(negedge clk);
      n_checks++;
      if (f_rsp_valid !== 1'b1 || fq.size() == 0) begin
         n_fail++; $display("FAIL newdata_valid: f_rsp_valid=%b required 1", f_rsp_valid);
      end else begin
         e = fq.pop_front(); n_checks++;
         if (f_rsp_data !== e.data || e.data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL newdata: data=%h required %h", f_rsp_data, 32'hDEAD_BEEF);
         end
      end
   endtask

   task automatic test_illegal();
      frsp_t e;
      logic  le;
      int    m0;
      logic [31:0] bad [2];
      bad[0] = 32'h0000_0002;
      bad[1] = 32'h0000_1000;
      m0 = men_count;
      for (int k = 0; k < 2; k++) begin
         issue_fetch(bad[k]);
         @(negedge clk);
         n_checks++;
         if (f_rsp_valid !== 1'b1 || fq.size() == 0) begin
            n_fail++; $display("FAIL ill_valid%0d: f_rsp_valid=%b required 1", k, f_rsp_valid);
         end else begin
            e = fq.pop_front(); n_checks++;
            if (f_rsp_data !== 32'h0 || f_rsp_err !== 1'b1 || e.err !== 1'b1) begin
               n_fail++;
               $display("FAIL ill_rsp%0d: data=%h err=%b required data=00000000 err=1", k, f_rsp_data, f_rsp_err);
            end
         end
      end
      load_word(32'h0000_1000, 32'h1234_5678);
      @(negedge clk);
      n_checks++;
      if (l_ack !== 1'b1 || lq.size() == 0) begin
         n_fail++; $display("FAIL ill_ack: l_ack=%b required 1", l_ack);
      end else begin
         le = lq.pop_front(); n_checks++;
         if (l_err !== 1'b1 || le !== 1'b1) begin
            n_fail++; $display("FAIL ill_lerr: l_err=%b required 1", l_err);
         end
      end
      n_checks++;
      if (men_count != m0) begin
         n_fail++; $display("FAIL ill_men: m_en pulses=%0d required 0", men_count - m0);
      end
   endtask

   task automatic test_arbitration();
      frsp_t e;
      logic  exp_l, prev_f, prev_l;
      issue_fetch(32'h0);
      @(negedge clk);
      if (fq.size() != 0) void'(fq.pop_front());
      @(posedge clk); #1;
      f_req_valid = 1'b1; f_addr = 32'h0;
      l_req_valid = 1'b1; l_addr = 32'h10; l_wdata = 32'h100;
      prev_f = 1'b0; prev_l = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (prev_f) begin
            n_checks++;
            if (f_rsp_valid !== 1'b1 || fq.size() == 0) begin
               n_fail++; $display("FAIL arb_rsp%0d: f_rsp_valid=%b required 1", i, f_rsp_valid);
            end else begin
               e = fq.pop_front(); n_checks++;
               if (f_rsp_data !== e.data) begin
                  n_fail++; $display("FAIL arb_data%0d: data=%h required %h", i, f_rsp_data, e.data);
               end
            end
         end
         if (prev_l) begin
            n_checks++;
            if (l_ack !== 1'b1 || lq.size() == 0) begin
               n_fail++; $display("FAIL arb_ack%0d: l_ack=%b required 1", i, l_ack);
            end else void'(lq.pop_front());
         end
         prev_f = 1'b0; prev_l = 1'b0;
         if (i < 4) begin
`ifdef IMEM_ARB_RR_EN
            exp_l = ((i % 2) == 0);
`else
            exp_l = 1'b1;
`endif
            n_checks++;
            if (l_req_ready !== exp_l || f_req_ready !== !exp_l) begin
               n_fail++;
               $display("FAIL arb_grant%0d: l_ready=%b f_ready=%b required l=%b f=%b", i, l_req_ready, f_req_ready, exp_l, !exp_l);
            end
            if (l_req_ready === 1'b1) begin
               lq.push_back(1'b0); ref_mem[4] = l_wdata; prev_l = 1'b1;
            end
            if (f_req_ready === 1'b1) begin
               fq.push_back(exp_fetch(f_addr)); prev_f = 1'b1;
            end
         end
         @(posedge clk); #1;
         l_wdata = l_wdata + 32'h1;
         if (i == 3) begin f_req_valid = 1'b0; l_req_valid = 1'b0; end
      end
   endtask

   task automatic test_reset_inflight();
      frsp_t e;
      issue_fetch(32'h4);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (f_rsp_valid !== 1'b0 || f_rsp_data !== 32'h0) begin
         n_fail++; $display("FAIL rst_rsp: f_rsp_valid=%b data=%h required 0 0", f_rsp_valid, f_rsp_data);
      end
      fq.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      load_word(32'hC, 32'h0000_0005);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (l_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: l_ack=%b required 0", l_ack); end
      lq.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (f_rsp_valid !== 1'b0 || l_ack !== 1'b0) begin
            n_fail++; $display("FAIL rst_after%0d: f_rsp_valid=%b l_ack=%b required 0 0", c, f_rsp_valid, l_ack);
         end
      end
      issue_fetch(32'hC);
      @(negedge clk);
      n_checks++;
      if (f_rsp_valid !== 1'b1 || fq.size() == 0) begin
         n_fail++; $display("FAIL rst_recover: f_rsp_valid=%b required 1", f_rsp_valid);
      end else begin
         e = fq.pop_front(); n_checks++;
         if (f_rsp_data !== e.data || e.data !== 32'h5) begin
            n_fail++; $display("FAIL rst_recover_data: data=%h required %h", f_rsp_data, 32'h5);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      test_reset();
      test_load_fetch();
      test_back_to_back();
      test_hold();
      test_illegal();
      test_arbitration();
      test_reset_inflight();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
